// File: rtl/rx_pkg.sv
// Shared helpers and types for the receive FIFO.
package rx_pkg;

    // Pointer width needed to address a store of the given depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Word type for the default byte-wide receive path.
    typedef logic [7:0] rx_word_t;

endpackage : rx_pkg

// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO control: read/write pointers, occupancy and the sticky
// overflow flag. Storage lives in the parent; this block only decides
// which pushes and pops are accepted.
module rx_fifo_ctrl
    import rx_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic          wr_ok,
    output logic [PW-1:0] wp,
    output logic [PW-1:0] rp,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic rd_ok;
    logic drop;

    // Flags come from the registered count only, never from the requests.
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A push into a full store is still accepted when a pop frees the
    // oldest slot in the same cycle; a pop from an empty store is ignored
    // even if a push arrives alongside it (no bypass).
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;
    assign drop  = wr_en && full && !rd_en;

    // Pointer, occupancy and overflow state.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + PW'(1);
            if (rd_ok) rp <= rp + PW'(1);

            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            // A dropped push beats a simultaneous clear.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule : rx_fifo_ctrl

// File: rtl/rx_fifo.sv
// Receive FIFO: DEPTH x DATA_WIDTH show-ahead buffer between the serial
// receiver and the processor read path, with occupancy, full/empty and a
// sticky overflow flag.
module rx_fifo
    import rx_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    localparam int PW         = ptr_w(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("rx_fifo: DEPTH (%0d) must be a power of two and at least 2", DEPTH);
    end
    if (DATA_WIDTH < 1) begin : g_width_chk
        $error("rx_fifo: DATA_WIDTH (%0d) must be at least 1", DATA_WIDTH);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic                  wr_ok;

    rx_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .wr_ok    (wr_ok),
        .wp       (wp),
        .rp       (rp),
        .cnt      (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // Storage write. When full with a simultaneous pop, wp == rp and the
    // new word lands in the slot the oldest word is leaving.
    // NOTE: the array has no reset; its contents are only observable
    // after a push, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wr_data;
    end

    // Show-ahead read: the oldest entry is always presented.
    assign rd_data = mem[rp];

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed scenarios plus randomized
// traffic, checked by a queue-based reference model and a negedge monitor.
module tb_rx_fifo;
    import rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    rx_word_t      wr_data;
    logic          rd_en;
    rx_word_t      rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clr;

    rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words plus the flag state
    // as it stands after the most recent clock edge.
    rx_word_t exp_q[$];
    int       m_cnt  = 0;
    bit       m_ovf  = 1'b0;
    bit       mon_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs with the model and retire
    // the head of the queue whenever a pop is being accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(count), 32'(m_cnt));
            check("empty", 32'(empty), 32'(m_cnt == 0));
            check("full", 32'(full), 32'(m_cnt == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (m_cnt > 0) begin
                check("rd_data", 32'(rd_data), 32'(exp_q[0]));
                if (rd_en) begin
                    rx_word_t w;
                    w = exp_q.pop_front();
                end
            end
        end
    end

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cycle(input bit wr, input rx_word_t wd, input bit rd, input bit clr);
        bit acc_w;
        bit acc_r;
        bit drop;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        ovf_clr = clr;
        acc_w = wr && ((m_cnt < DEPTH) || rd);
        acc_r = rd && (m_cnt > 0);
        drop  = wr && !rd && (m_cnt == DEPTH);
        if (acc_w) exp_q.push_back(wd);
        @(posedge clk);
        m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic push(input rx_word_t wd);
        cycle(1'b1, wd, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic drain();
        while (m_cnt > 0) pop();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Basic ordering.
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        pop();
        pop();
        pop();
        check("basic_empty_end", 32'(empty), 32'd1);

        // Fill, then a dropped push sets overflow.
        for (int i = 0; i < DEPTH; i++) push(rx_word_t'(8'h10 + i));
        push(8'hFF);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd1);
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) push(rx_word_t'(8'h10 + i));
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("fullrw_count", 32'(count), 32'(DEPTH));
        check("fullrw_overflow", 32'(overflow), 32'd0);
        drain();

        // Empty with simultaneous push and pop, then pop on empty.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_data", 32'(rd_data), 32'h3C);
        pop();
        pop();
        check("underflow_count", 32'(count), 32'd0);

        // Overflow clear, then clear colliding with a dropped push.
        for (int i = 0; i < DEPTH; i++) push(rx_word_t'($urandom_range(255)));
        push(8'hEE);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Mid-operation reset with five words stored.
        pop();
        pop();
        pop();
        check("pre_reset_count", 32'(count), 32'd5);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        push(8'h7E);
        check("post_reset_first", 32'(rd_data), 32'h7E);
        drain();

        // Wrap-around: interleaved pushes and pops across the pointer wrap.
        for (int i = 0; i < 3; i++) push(rx_word_t'($urandom_range(255)));
        for (int i = 0; i < 20; i++) begin
            push(rx_word_t'($urandom_range(255)));
            pop();
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, rx_word_t'($urandom_range(255)), 1'b1, 1'b0);
        drain();

        // Randomized traffic in phases biased toward filling and draining.
        for (int phase = 0; phase < 6; phase++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (phase % 2 == 0) ? 80 : 30;
            rd_pct = (phase % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 100; i++) begin
                cycle(($urandom_range(99) < wr_pct),
                      rx_word_t'($urandom_range(255)),
                      ($urandom_range(99) < rd_pct),
                      ($urandom_range(99) < 10));
            end
        end
        drain();
        @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rx_fifo

// File: doc/rx_fifo.md
# rx_fifo

Parametrised receive buffer for the serial peripheral path. It generalises the single enabled byte register into a DEPTH-entry first-in-first-out store of DATA_WIDTH-bit words. Received bytes queue here until the processor's memory-mapped read path drains them. It reports occupancy, full and empty, and keeps a sticky overflow flag.

## Interface
- DATA_WIDTH, 8, word width in bits, ≥1
- DEPTH, 8, number of entries; power of two, ≥2
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-low
- wr_en  input  1  push request
- wr_data  input  DATA_WIDTH  word to push
- rd_en  input  1  pop request
- rd_data  output  DATA_WIDTH  oldest entry (show-ahead)
- empty  output  1  no entries stored
- full  output  1  DEPTH entries stored
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was dropped
- ovf_clr  input  1  clears overflow

## Operation
- Storage is a DEPTH×DATA_WIDTH array.
- Write pointer wp and read pointer rp are each $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy register cnt drives count; full = (cnt==DEPTH), empty = (cnt==0).
- Push accepted (acc_w) when wr_en && (!full || rd_en).
  - mem[wp] ← wr_data; wp ← wp+1.
- Pop accepted (acc_r) when rd_en && !empty.
  - rp ← rp+1.
- cnt update:
  - +1 when only acc_w.
  - −1 when only acc_r.
  - Unchanged when both or neither.
- Full + wr_en + rd_en: both are accepted. The oldest word leaves, the new word is written into the freed slot (wp==rp), and count stays DEPTH.
- Empty + wr_en + rd_en: the push is accepted and the pop is ignored, so count becomes 1. There is no write-to-read bypass.
- Full + wr_en without rd_en: the word is dropped and memory and pointers are unchanged. overflow ← 1 on the next edge.
- Empty + rd_en: ignored, with no state change. No underflow flag is kept.
- overflow is sticky until ovf_clr is asserted. If ovf_clr coincides with a new dropped push, set wins and overflow stays 1.
- rd_data = mem[rp], combinational from the registered rp and array. Its value is don't-care while empty; benches must not check it then.
- Reset clears wp, rp, cnt and overflow.
  - Outputs after reset: empty=1, full=0, count=0, overflow=0.
  - Array contents are not reset; rd_data is undefined until the first push.
- Reset asserted mid-operation discards all queued data immediately, without waiting for a clock edge.

## Timing
- All state updates on the rising edge of clk; reset acts asynchronously on its falling edge.
- Push-to-visible latency is 1 cycle. A word pushed at edge N appears on rd_data, with empty=0, after edge N when the FIFO was empty.
- A pop at edge N presents the next word on rd_data after edge N.
- Flags and count reflect the state after the most recent edge. They are registered, not combinational from wr_en/rd_en.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Package rx_pkg holds:
  - Function ptr_w(depth) = $clog2(depth).
  - Typedef rx_word_t (logic [7:0]) for the default byte path.
- Elaboration check: DEPTH must be a power of two; otherwise $error.
- Sub-module rx_fifo_ctrl holds pointers, cnt and the flag logic. The parent holds the storage array and read mux.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3 and pop three times:
  - rd_data shows A1, B2, C3 in order.
  - count goes 1,2,3 then 2,1,0.
  - empty=1 at the end.
- Push 8 words 0x10..0x17 (DEPTH=8), then push 0xFF with rd_en=0:
  - full=1, count=8, overflow=1.
  - Popping all yields 0x10..0x17; 0xFF is never seen.
- Fill to full, then push 0x55 with rd_en=1 in the same cycle:
  - count stays 8 and overflow stays 0.
  - The drain yields 0x11..0x17 then 0x55.
- Empty FIFO with wr_en=rd_en=1, wr_data=0x3C: count=1, rd_data=0x3C next cycle. Then rd_en on empty: no change.
- Set overflow, then assert ovf_clr alone: overflow=0. Then, with FIFO full, drive ovf_clr and a dropped push together: overflow=1.
- Mid-operation reset with count=5, asserted between edges:
  - empty=1, count=0, overflow=0 immediately.
  - After release, pushing 0x7E then shows 0x7E first.
- Wrap-around: run 20 interleaved push/pop pairs across the pointer wrap and check order is preserved.
